// File: rtl/sobel_window_3x3.sv
// sobel_window_3x3
//   Streaming 3x3 Sobel edge stage placed directly after the tapped line
//   buffer. Each accepted pixel column {row2, row1, row0} enters a 3x3
//   window; Gx/Gy are formed, then a saturated |Gx|+|Gy| magnitude, a
//   threshold flag and the window-centre coordinates are emitted two clocks
//   after the accepting shift.
//
//   Optional feature: define SOBEL_EDGE_DIR_EN to add the edge_dir output
//   (00 |Gx|>|Gy|, 01 |Gy|>|Gx|, 10 equal and nonzero, 11 both zero).
//
// Parameters
//   LINE_W  pixels per line, equal to the line-buffer tap spacing (4..64)
//   THRESH  8-bit edge threshold applied to the saturated magnitude
//
// Ports
//   clk          rising-edge clock (line-buffer domain)
//   rst_n        asynchronous active-low reset
//   shift        pixel strobe shared with the line buffer
//   frame_start  synchronous restart of the coordinate counters
//   row0         newest pixel (line-buffer input)
//   row1         line-buffer tap one (one line older)
//   row2         line-buffer tap two (two lines older)
//   out_valid    output qualifier, one pulse per qualifying window
//   edge_mag     |Gx|+|Gy| saturated to 255
//   edge_bit     edge_mag >= THRESH
//   out_col      column of the window centre pixel
//   out_row      line of the window centre pixel
//   edge_dir     (SOBEL_EDGE_DIR_EN only) dominant gradient direction

module sobel_window_3x3 #(
  parameter int unsigned LINE_W = 16,
  parameter int unsigned THRESH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift,
  input  logic       frame_start,
  input  logic [7:0] row0,
  input  logic [7:0] row1,
  input  logic [7:0] row2,
  output logic       out_valid,
  output logic [7:0] edge_mag,
  output logic       edge_bit,
  output logic [5:0] out_col,
  output logic [7:0] out_row
`ifdef SOBEL_EDGE_DIR_EN
  ,
  output logic [1:0] edge_dir
`endif
);

  localparam logic [5:0] LAST_COL = 6'(LINE_W - 1);
  localparam logic [7:0] TH8      = 8'(THRESH);

  // Window: r_win[row][col], row 0 = top (oldest line), col 2 = newest.
  logic [7:0] r_win [3][3];
  logic [7:0] w_nw  [3][3];

  logic [5:0] r_col;
  logic [7:0] r_row;
  logic [5:0] w_col_tag;
  logic [7:0] w_row_tag;
  logic       w_wrap;
  logic       w_qual;

  logic        [10:0] w_gx_p, w_gx_n, w_gy_p, w_gy_n;
  logic signed [10:0] w_gx, w_gy;

  logic signed [10:0] r_s1_gx, r_s1_gy;
  logic               r_s1_valid;
  logic        [5:0]  r_s1_col;
  logic        [7:0]  r_s1_row;

  logic [10:0] w_ax, w_ay, w_sum;
  logic [7:0]  w_mag;

  // ---------------------------------------------------------------------------
  // Window as it will look once the current pixel is accepted. Gradients are
  // taken from this view so stage 1 can be loaded on the shift edge itself,
  // giving the two-clock latency from the accepting shift.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 2; c++) begin
        w_nw[r][c] = r_win[r][c+1];
      end
    end
    w_nw[0][2] = row2;
    w_nw[1][2] = row1;
    w_nw[2][2] = row0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (shift) begin
      r_win <= w_nw;
    end
  end

  // ---------------------------------------------------------------------------
  // Coordinate counters. frame_start retags the pixel of the same cycle as
  // col 0 / row 0, so the tag itself is muxed before it is used.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_col_tag = frame_start ? '0 : r_col;
    w_row_tag = frame_start ? '0 : r_row;
    w_wrap    = (w_col_tag == LAST_COL);
    w_qual    = (w_col_tag >= 6'd2) && (w_row_tag >= 8'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (shift) begin
      if (w_wrap) begin
        r_col <= '0;
        r_row <= (w_row_tag == 8'hFF) ? w_row_tag : w_row_tag + 8'd1;
      end else begin
        r_col <= w_col_tag + 6'd1;
        r_row <= w_row_tag;
      end
    end else if (frame_start) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Gradients (11-bit signed, -1020..1020)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_gx_p = 11'(w_nw[0][2]) + {2'b00, w_nw[1][2], 1'b0} + 11'(w_nw[2][2]);
    w_gx_n = 11'(w_nw[0][0]) + {2'b00, w_nw[1][0], 1'b0} + 11'(w_nw[2][0]);
    w_gy_p = 11'(w_nw[2][0]) + {2'b00, w_nw[2][1], 1'b0} + 11'(w_nw[2][2]);
    w_gy_n = 11'(w_nw[0][0]) + {2'b00, w_nw[0][1], 1'b0} + 11'(w_nw[0][2]);
    w_gx   = w_gx_p - w_gx_n;
    w_gy   = w_gy_p - w_gy_n;
  end

  // Stage 1: free-running; only the valid bit depends on shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_gx    <= '0;
      r_s1_gy    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_col   <= '0;
      r_s1_row   <= '0;
    end else begin
      r_s1_gx    <= w_gx;
      r_s1_gy    <= w_gy;
      r_s1_valid <= shift && w_qual;
      r_s1_col   <= w_col_tag - 6'd1;
      r_s1_row   <= w_row_tag - 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Magnitude: |Gx|+|Gy| fits 11 bits unsigned (max 2040), saturated to 8.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ax  = r_s1_gx[10] ? (~r_s1_gx + 11'd1) : r_s1_gx;
    w_ay  = r_s1_gy[10] ? (~r_s1_gy + 11'd1) : r_s1_gy;
    w_sum = w_ax + w_ay;
    w_mag = (|w_sum[10:8]) ? 8'hFF : w_sum[7:0];
  end

  // Stage 2: result fields hold while no new window arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      edge_mag  <= '0;
      edge_bit  <= 1'b0;
      out_col   <= '0;
      out_row   <= '0;
    end else begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        edge_mag <= w_mag;
        edge_bit <= (w_mag >= TH8);
        out_col  <= r_s1_col;
        out_row  <= r_s1_row;
      end
    end
  end

`ifdef SOBEL_EDGE_DIR_EN
  logic [1:0] w_dir;

  always_comb begin
    if (w_ax > w_ay) begin
      w_dir = 2'b00;
    end else if (w_ay > w_ax) begin
      w_dir = 2'b01;
    end else if (w_ax != 11'd0) begin
      w_dir = 2'b10;
    end else begin
      w_dir = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_dir <= '0;
    end else if (r_s1_valid) begin
      edge_dir <= w_dir;
    end
  end
`endif

endmodule
